// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder: registered 8-to-3 priority encoder with sticky
// falling-edge request capture and a valid/ready output handshake.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   G        in   capture enable (1 = accept new request edges)
//   I_n[7:0] in   active-low request lines
//   ready    in   downstream accepts the presented code
//   A[2:0]   out  index of presented request (7 = highest priority)
//   valid    out  A holds a pending request
//   pending  out  sticky pending-request mask
//   overrun  out  sticky: a request merged with one already pending
module seq_priority_encoder #(
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       G,
    input  logic [7:0] I_n,
    input  logic       ready,
    output logic [2:0] A,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overrun
);

    logic [7:0] s;
    logic [7:0] p_q;
    logic [7:0] pend_q, pend_d;
    logic [2:0] a_q, a_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic [7:0] fall;
    logic [7:0] clr;

    generate
        if (SYNC == 0) begin : g_nosync
            assign s = I_n;
        end else begin : g_sync
            logic [7:0] sync_q [SYNC];

            // Chain resets to 1 so a line held low through reset
            // still shows up as one falling edge afterwards.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC; k++) sync_q[k] <= 8'hFF;
                end else begin
                    sync_q[0] <= I_n;
                    for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
                end
            end

            assign s = sync_q[SYNC-1];
        end
    endgenerate

    function automatic logic [2:0] hi_idx(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = i[2:0];
        end
        return r;
    endfunction

    always_comb begin
        clr = '0;
        if (valid_q && ready) clr = 8'd1 << a_q;
        // p tracks s even while G=0, so a line held low during
        // disable never fires once G returns.
        fall    = p_q & ~s & {8{G}};
        // A new edge on the line being retired re-arms it.
        pend_d  = (pend_q & ~clr) | fall;
        ovr_d   = ovr_q | (|(fall & pend_q & ~clr));
        valid_d = valid_q;
        a_d     = a_q;
        // Output only moves when empty or consumed: no preemption.
        if (!valid_q || ready) begin
            valid_d = |pend_d;
            if (|pend_d) a_d = hi_idx(pend_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= 8'hFF;
            pend_q  <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            p_q     <= s;
            pend_q  <= pend_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign A       = a_q;
    assign valid   = valid_q;
    assign pending = pend_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb_seq_priority_encoder: directed and randomized checks of the
// sequential priority encoder against a set-based reference model.
module tb_seq_priority_encoder;

    localparam int SYNC = 2;

    logic       clk;
    logic       rst_n;
    logic       G;
    logic [7:0] I_n;
    logic       ready;
    logic [2:0] A;
    logic       valid;
    logic [7:0] pending;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    seq_priority_encoder #(.SYNC(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .G       (G),
        .I_n     (I_n),
        .ready   (ready),
        .A       (A),
        .valid   (valid),
        .pending (pending),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of sampled inputs, a pending set,
    // and the presented (valid, index) pair.
    logic [7:0] hist[$];
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_A;
    logic       m_ovr;

    function automatic void m_reset();
        hist.delete();
        for (int k = 0; k < SYNC; k++) hist.push_back(8'hFF);
        m_prev  = 8'hFF;
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_A     = 3'd0;
        m_ovr   = 1'b0;
    endfunction

    task automatic model_edge();
        logic [7:0] sv;
        logic       fell;
        logic       taken;
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (SYNC == 0) begin
            sv = I_n;
        end else begin
            sv = hist.pop_front();
            hist.push_back(I_n);
        end
        for (int i = 0; i < 8; i++) begin
            fell  = G && m_prev[i] && !sv[i];
            taken = m_valid && ready && (m_A == i);
            if (taken) m_pend[i] = 1'b0;
            if (fell) begin
                if (m_pend[i]) m_ovr = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
        m_prev = sv;
        if (!m_valid || ready) begin
            m_valid = (m_pend != 8'h00);
            if (m_valid) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_pend[i]) m_A = 3'(i);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        chk("model_valid", 32'(valid), 32'(m_valid));
        chk("model_A", 32'(A), 32'(m_A));
        chk("model_pending", 32'(pending), 32'(m_pend));
        chk("model_overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cmp_model();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [2:0] a, input logic [7:0] p);
        chk({tag, "_valid"}, 32'(valid), 32'(v));
        chk({tag, "_A"}, 32'(A), 32'(a));
        chk({tag, "_pending"}, 32'(pending), 32'(p));
    endtask

    initial begin
        rst_n = 1'b1;
        G     = 1'b1;
        I_n   = 8'hFF;
        ready = 1'b0;
        m_reset();

        // Reset from power-up
        #2 rst_n = 1'b0;
        #1;
        chk_out("reset0", 1'b0, 3'd0, 8'h00);
        chk("reset0_overrun", 32'(overrun), 32'd0);
        steps(2);
        rst_n = 1'b1;
        steps(5);
        chk("idle_valid", 32'(valid), 32'd0);

        // Single request on line 2, held
        I_n = 8'hFB;
        steps(3);
        chk_out("single", 1'b1, 3'd2, 8'h04);
        steps(10);
        chk_out("single_hold", 1'b1, 3'd2, 8'h04);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk_out("single_acc", 1'b0, 3'd2, 8'h00);
        steps(3);
        chk("no_retrigger", 32'(valid), 32'd0);
        I_n = 8'hFF;
        steps(3);

        // Simultaneous requests 7, 5, 1 drained back to back
        ready = 1'b1;
        I_n = 8'h5D;
        steps(3);
        chk_out("multi_7", 1'b1, 3'd7, 8'hA2);
        step();
        chk_out("multi_5", 1'b1, 3'd5, 8'h22);
        step();
        chk_out("multi_1", 1'b1, 3'd1, 8'h02);
        step();
        chk("multi_done", 32'(valid), 32'd0);
        I_n = 8'hFF;
        ready = 1'b0;
        steps(3);

        // No preemption of a stalled code
        I_n = 8'hF7;
        steps(3);
        chk_out("np_3", 1'b1, 3'd3, 8'h08);
        I_n = 8'hB7;
        steps(4);
        chk_out("np_hold", 1'b1, 3'd3, 8'h48);
        ready = 1'b1;
        step();
        chk_out("np_6", 1'b1, 3'd6, 8'h40);
        step();
        chk("np_done", 32'(valid), 32'd0);
        ready = 1'b0;
        I_n = 8'hFF;
        steps(3);

        // Enable gating
        G = 1'b0;
        I_n = 8'hEF;
        steps(4);
        chk_out("gate_off", 1'b0, 3'd6, 8'h00);
        G = 1'b1;
        steps(4);
        chk("gate_late_pend", 32'(pending), 32'd0);
        I_n = 8'hFF;
        steps(3);
        I_n = 8'hEF;
        steps(3);
        chk_out("gate_on", 1'b1, 3'd4, 8'h10);
        ready = 1'b1;
        step();
        ready = 1'b0;
        I_n = 8'hFF;
        steps(3);

        // Overrun: two pulses on line 0 while stalled
        I_n = 8'hFE;
        steps(3);
        I_n = 8'hFF;
        steps(3);
        I_n = 8'hFE;
        steps(3);
        I_n = 8'hFF;
        steps(4);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk_out("ovr", 1'b1, 3'd0, 8'h01);
        ready = 1'b1;
        step();
        chk("ovr_one_code", 32'(valid), 32'd0);
        steps(3);
        ready = 1'b0;
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset mid-activity
        I_n = 8'h00;
        steps(4);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_out("reset_mid", 1'b0, 3'd0, 8'h00);
        chk("reset_mid_overrun", 32'(overrun), 32'd0);
        I_n = 8'hFF;
        steps(2);
        rst_n = 1'b1;
        steps(5);
        chk("reset_mid_idle", 32'(valid), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) I_n = I_n ^ 8'($urandom);
            G     = ($urandom_range(7) != 0);
            ready = ($urandom_range(2) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
